// File: rtl/nmea_sentence_tx.sv
// Serialises one "$GPRMC,HHMMSS.00,S[*CC]\r\n" sentence as 8N1 UART per start request.
// Define NMEA_TX_CKSUM_EN to append the "*CC" checksum field (23 chars instead of 20).
module nmea_sentence_tx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       fix,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef NMEA_TX_CKSUM_EN
    localparam int NUM_CHARS    = 23;
`else
    localparam int NUM_CHARS    = 20;
`endif

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [4:0]       CHAR_LAST = 5'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA,
        STOP_BIT,
        NEXT_CHAR,
        FINISH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [4:0]       char_idx;
    logic [4:0]       hr_q;
    logic [5:0]       min_q;
    logic [5:0]       sec_q;
    logic             fix_q;
`ifdef NMEA_TX_CKSUM_EN
    logic [7:0]       cksum;
`endif

    logic [15:0] hr_d;
    logic [15:0] min_d;
    logic [15:0] sec_d;
    logic [7:0]  cur_char;

    // Fixed-depth subtract-ten ladder: the same combinational path for every value 0..63.
    function automatic logic [15:0] dec2(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        for (int i = 0; i < 6; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {4'h3, t, 4'h3, r[3:0]};
    endfunction

`ifdef NMEA_TX_CKSUM_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    assign hr_d  = dec2({1'b0, hr_q});
    assign min_d = dec2(min_q);
    assign sec_d = dec2(sec_q);

    // NOTE: cur_char gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            5'd0:  cur_char = "$";
            5'd1:  cur_char = "G";
            5'd2:  cur_char = "P";
            5'd3:  cur_char = "R";
            5'd4:  cur_char = "M";
            5'd5:  cur_char = "C";
            5'd6:  cur_char = ",";
            5'd7:  cur_char = hr_d[15:8];
            5'd8:  cur_char = hr_d[7:0];
            5'd9:  cur_char = min_d[15:8];
            5'd10: cur_char = min_d[7:0];
            5'd11: cur_char = sec_d[15:8];
            5'd12: cur_char = sec_d[7:0];
            5'd13: cur_char = ".";
            5'd14: cur_char = "0";
            5'd15: cur_char = "0";
            5'd16: cur_char = ",";
            5'd17: cur_char = fix_q ? "A" : "V";
`ifdef NMEA_TX_CKSUM_EN
            5'd18: cur_char = "*";
            5'd19: cur_char = hex_ascii(cksum[7:4]);
            5'd20: cur_char = hex_ascii(cksum[3:0]);
            5'd21: cur_char = 8'h0D;
            5'd22: cur_char = 8'h0A;
`else
            5'd18: cur_char = 8'h0D;
            5'd19: cur_char = 8'h0A;
`endif
            default: cur_char = 8'h0A;
        endcase
    end

    // LOAD is the first cycle of the '$' start bit and NEXT_CHAR the last cycle of each
    // stop bit, so characters stay back to back with every bit exactly CLKS_PER_BIT long.
    // NOTE: every state register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            hr_q     <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            fix_q    <= 1'b0;
`ifdef NMEA_TX_CKSUM_EN
            cksum    <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        state    <= LOAD;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        char_idx <= '0;
                        hr_q     <= hr;
                        min_q    <= min;
                        sec_q    <= sec;
                        fix_q    <= fix;
`ifdef NMEA_TX_CKSUM_EN
                        cksum    <= 8'h00;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    state    <= START_BIT;
                    baud_cnt <= CNT_W'(1);
                end
                START_BIT: begin
                    if (baud_cnt == BIT_LAST) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= cur_char[0];
`ifdef NMEA_TX_CKSUM_EN
                        if (char_idx != 5'd0 && char_idx < 5'd18)
                            cksum <= cksum ^ cur_char;
`endif
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP_BIT: begin
                    baud_cnt <= baud_cnt + CNT_W'(1);
                    if (baud_cnt == STOP_LAST)
                        state <= NEXT_CHAR;
                end
                NEXT_CHAR: begin
                    baud_cnt <= '0;
                    if (char_idx == CHAR_LAST) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= START_BIT;
                        char_idx <= char_idx + 5'd1;
                        tx       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_sentence_tx.sv
// Directed bench for nmea_sentence_tx: decodes tx at mid-bit and checks text, framing and timing.
// Build with or without NMEA_TX_CKSUM_EN; expected sentences follow the same macro.
module tb_nmea_sentence_tx;

    localparam int CPB = 10;
`ifdef NMEA_TX_CKSUM_EN
    localparam string EXP_A = "$GPRMC,123456.00,A*23\015\012";
    localparam string EXP_V = "$GPRMC,123456.00,V*34\015\012";
    localparam string EXP_T = "$GPRMC,050009.00,A*28\015\012";
`else
    localparam string EXP_A = "$GPRMC,123456.00,A\015\012";
    localparam string EXP_V = "$GPRMC,123456.00,V\015\012";
    localparam string EXP_T = "$GPRMC,050009.00,A\015\012";
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       fix;
    logic       tx;
    logic       busy;
    logic       done;

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int done_count = 0;

    nmea_sentence_tx #(.CLK_HZ(100), .BAUD(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .hr    (hr),
        .min   (min),
        .sec   (sec),
        .fix   (fix),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string hexstr(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h", r, s[i]);
        return r;
    endfunction

    task automatic check_str(input string tag, input string got, input string exp);
        n_tests++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %s expected %s (hex)", tag, hexstr(got), hexstr(exp));
        end
    endtask

    task automatic launch(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                          input logic f);
        @(negedge clk);
        hr    = h;
        min   = m;
        sec   = s;
        fix   = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the first negedge after the accepting edge; optionally requests the
    // next sentence in the done cycle.
    task automatic run_sentence(input string exp, input string tag, input bit chain);
        int         a;
        int         frame_err;
        string      got;
        logic [7:0] ch;
        a         = cyc;
        frame_err = 0;
        got       = "";
        ch        = 8'h00;
        check({tag, "_tx_low"}, {31'd0, tx}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int c = 0; c < exp.len(); c++) begin
            for (int b = 0; b < 10; b++) begin
                repeat ((c == 0 && b == 0) ? (CPB / 2 - 1) : CPB) @(negedge clk);
                if (busy !== 1'b1 || done !== 1'b0) frame_err++;
                if (b == 0) begin
                    if (tx !== 1'b0) frame_err++;
                end else if (b == 9) begin
                    if (tx !== 1'b1) frame_err++;
                end else begin
                    ch[b-1] = tx;
                end
            end
            got = $sformatf("%s%c", got, ch);
        end
        check({tag, "_framing"}, frame_err, 32'd0);
        check_str({tag, "_text"}, got, exp);
        for (int k = 0; k < 50 && done !== 1'b1; k++) @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_done_time"}, cyc - a, exp.len() * 10 * CPB);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        if (chain) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check(tag, bad, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hr    = '0;
        min   = '0;
        sec   = '0;
        fix   = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        idle_watch("idle_after_reset", 20);

        // 12:34:56 fix=1, then the fix=0 sentence requested in the done cycle.
        launch(5'd12, 6'd34, 6'd56, 1'b1);
        fix = 1'b0;
        run_sentence(EXP_A, "s1_fixA", 1'b1);
        run_sentence(EXP_V, "s2_fixV", 1'b0);

        // Leading zeros; start re-pulsed with new inputs while busy must change nothing.
        launch(5'd5, 6'd0, 6'd9, 1'b1);
        fork
            run_sentence(EXP_T, "s3_zeros", 1'b0);
            begin
                repeat (300) @(negedge clk);
                start = 1'b1;
                hr    = 5'd23;
                min   = 6'd59;
                sec   = 6'd59;
                fix   = 1'b0;
                @(negedge clk);
                start = 1'b0;
                repeat (900) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        idle_watch("no_queued_start", 3 * 10 * CPB);
        check("done_count_s3", done_count, 32'd3);

        // Reset during the DATA bits of character 10.
        launch(5'd12, 6'd34, 6'd56, 1'b1);
        repeat (1030) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        idle_watch("idle_after_abort", 200);
        check("done_count_abort", done_count, 32'd3);

        launch(5'd12, 6'd34, 6'd56, 1'b1);
        run_sentence(EXP_A, "s4_after_abort", 1'b0);
        check("done_count_final", done_count, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
